// File: rtl/cordic_sweep_ctrl_if.sv
// Interface bundling the sweep controller's configuration, handshake and
// frequency output signals. The master side configures the sweep and observes
// the results. The slave side is the sweep controller.
interface cordic_sweep_ctrl_if #(
   parameter int FREQ_WIDTH  = 8,
   parameter int DWELL_WIDTH = 16
);
   logic                   start_i;
   logic                   abort_i;
   logic [1:0]             mode_i;
   logic [FREQ_WIDTH-1:0]  f_start_i;
   logic [FREQ_WIDTH-1:0]  f_stop_i;
   logic [FREQ_WIDTH-1:0]  f_step_i;
   logic [DWELL_WIDTH-1:0] dwell_i;
   logic [FREQ_WIDTH-1:0]  freq_o;
   logic                   step_o;
   logic                   busy_o;
   logic                   done_o;
   logic                   err_o;

   modport master (
      output start_i, abort_i, mode_i, f_start_i, f_stop_i, f_step_i, dwell_i,
      input  freq_o, step_o, busy_o, done_o, err_o
   );

   modport slave (
      input  start_i, abort_i, mode_i, f_start_i, f_stop_i, f_step_i, dwell_i,
      output freq_o, step_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/cordic_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDFS chain. It steps the frequency word
// fed to the angle accumulator from a start value towards a stop value, and
// holds each value for a programmable dwell. Three sweep shapes are supported:
// a single up-ramp, a continuous ramp and a triangle.
module cordic_sweep_ctrl #(
   parameter int FREQ_WIDTH  = 8,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   cordic_sweep_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
   logic                   step_q, step_d;
   logic                   err_q, err_d;
   logic                   dir_down_q, dir_down_d;
   logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
   logic [1:0]             mode_q, mode_d;
   logic [FREQ_WIDTH-1:0]  f_start_q, f_start_d;
   logic [FREQ_WIDTH-1:0]  f_stop_q, f_stop_d;
   logic [FREQ_WIDTH-1:0]  f_step_q, f_step_d;

   logic [FREQ_WIDTH:0]    nxt_up;
   logic [FREQ_WIDTH:0]    nxt_dn;
   logic                   up_ok;
   logic                   dn_ok;
   logic [DWELL_WIDTH-1:0] dwell_eff;

   // Candidate next values use one extra bit, so that an overshoot past the
   // top or an undershoot below zero is detected instead of wrapping.
   always_comb begin
      nxt_up    = {1'b0, freq_q} + {1'b0, f_step_q};
      nxt_dn    = {1'b0, freq_q} - {1'b0, f_step_q};
      up_ok     = (nxt_up <= {1'b0, f_stop_q});
      dn_ok     = ($signed(nxt_dn) >= $signed({1'b0, f_start_q}));
      dwell_eff = (bus.dwell_i == '0) ? DWELL_ONE : bus.dwell_i;
   end

   // Next-state logic: start acceptance and config capture, dwell counting,
   // and ramp stepping for each mode. Abort takes priority over a due step.
   always_comb begin
      state_d    = state_q;
      freq_d     = freq_q;
      step_d     = 1'b0;
      err_d      = 1'b0;
      dir_down_d = dir_down_q;
      cnt_d      = cnt_q;
      dwell_d    = dwell_q;
      mode_d     = mode_q;
      f_start_d  = f_start_q;
      f_stop_d   = f_stop_q;
      f_step_d   = f_step_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               if ((bus.f_step_i != '0) && (bus.f_start_i <= bus.f_stop_i)) begin
                  state_d    = RUN;
                  freq_d     = bus.f_start_i;
                  step_d     = 1'b1;
                  dir_down_d = 1'b0;
                  dwell_d    = dwell_eff;
                  cnt_d      = dwell_eff - DWELL_ONE;
                  mode_d     = bus.mode_i;
                  f_start_d  = bus.f_start_i;
                  f_stop_d   = bus.f_stop_i;
                  f_step_d   = bus.f_step_i;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.abort_i) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_ONE;
            end else begin
               cnt_d = dwell_q - DWELL_ONE;
               if (!dir_down_q) begin
                  if (up_ok) begin
                     freq_d = nxt_up[FREQ_WIDTH-1:0];
                     step_d = 1'b1;
                  end else begin
                     case (mode_q)
                        2'b01: begin
                           freq_d = f_start_q;
                           step_d = 1'b1;
                        end
                        2'b10: begin
                           dir_down_d = 1'b1;
                           freq_d     = dn_ok ? nxt_dn[FREQ_WIDTH-1:0] : f_start_q;
                           step_d     = 1'b1;
                        end
                        default: state_d = FINISH;
                     endcase
                  end
               end else begin
                  step_d = 1'b1;
                  if (dn_ok) begin
                     freq_d = nxt_dn[FREQ_WIDTH-1:0];
                  end else begin
                     dir_down_d = 1'b0;
                     freq_d     = up_ok ? nxt_up[FREQ_WIDTH-1:0] : f_start_q;
                  end
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         freq_q     <= '0;
         step_q     <= 1'b0;
         err_q      <= 1'b0;
         dir_down_q <= 1'b0;
         cnt_q      <= '0;
         dwell_q    <= '0;
         mode_q     <= '0;
         f_start_q  <= '0;
         f_stop_q   <= '0;
         f_step_q   <= '0;
      end else begin
         state_q    <= state_d;
         freq_q     <= freq_d;
         step_q     <= step_d;
         err_q      <= err_d;
         dir_down_q <= dir_down_d;
         cnt_q      <= cnt_d;
         dwell_q    <= dwell_d;
         mode_q     <= mode_d;
         f_start_q  <= f_start_d;
         f_stop_q   <= f_stop_d;
         f_step_q   <= f_step_d;
      end
   end

   // Outputs come directly from registers. Busy and done are decoded from the state.
   always_comb begin
      bus.freq_o = freq_q;
      bus.step_o = step_q;
      bus.err_o  = err_q;
      bus.busy_o = (state_q == RUN);
      bus.done_o = (state_q == FINISH);
   end

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Directed bench for cordic_sweep_ctrl. Each expected output vector
// {freq, step, busy, done, err} is queued when stimulus is driven. The vector
// is then popped and compared one cycle later, #1 after the rising edge.
module tb_cordic_sweep_ctrl;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   logic [11:0] exp_q[$];

   cordic_sweep_ctrl_if #(.FREQ_WIDTH(8), .DWELL_WIDTH(16)) bus ();

   cordic_sweep_ctrl #(.FREQ_WIDTH(8), .DWELL_WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic pushExp(input logic [7:0] f, input logic s, input logic b,
                          input logic d, input logic e, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({f, s, b, d, e});
   endtask

   task automatic checkOutput(input string tag, input int n);
      logic [11:0] want;
      logic [11:0] obs;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         obs = {bus.freq_o, bus.step_o, bus.busy_o, bus.done_o, bus.err_o};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s: scoreboard empty, observed=%h", tag, obs);
         end else begin
            want = exp_q.pop_front();
            assert (obs === want) else begin
               errors++;
               $error("[TB] FAIL %s[%0d]: observed freq=%0d step=%b busy=%b done=%b err=%b, expected freq=%0d step=%b busy=%b done=%b err=%b",
                      tag, i, obs[11:4], obs[3], obs[2], obs[1], obs[0],
                      want[11:4], want[3], want[2], want[1], want[0]);
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [1:0] md, input logic [7:0] fs,
                                input logic [7:0] fp, input logic [7:0] st,
                                input logic [15:0] dw);
      bus.mode_i    = md;
      bus.f_start_i = fs;
      bus.f_stop_i  = fp;
      bus.f_step_i  = st;
      bus.dwell_i   = dw;
      bus.start_i   = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start_i   = 1'b0;
      bus.abort_i   = 1'b0;
      bus.mode_i    = 2'b00;
      bus.f_start_i = '0;
      bus.f_stop_i  = '0;
      bus.f_step_i  = '0;
      bus.dwell_i   = '0;

      // Reset state
      pushExp(8'd0, 0, 0, 0, 0, 1);
      checkOutput("reset", 1);
      rst_n = 1'b1;

      // Single up-ramp 10..20 step 5 dwell 4, with mid-sweep input changes
      applyStimulus(2'b00, 8'd10, 8'd20, 8'd5, 16'd4);
      pushExp(8'd10, 1, 1, 0, 0, 1);
      checkOutput("single_start", 1);
      bus.mode_i = 2'b01; bus.f_stop_i = 8'd200; bus.f_step_i = 8'd1; bus.dwell_i = 16'd1;
      pushExp(8'd10, 0, 1, 0, 0, 3);
      checkOutput("single_hold10", 3);
      pushExp(8'd15, 1, 1, 0, 0, 1);
      checkOutput("single_step15", 1);
      bus.start_i = 1'b0;
      pushExp(8'd15, 0, 1, 0, 0, 3);
      pushExp(8'd20, 1, 1, 0, 0, 1);
      pushExp(8'd20, 0, 1, 0, 0, 3);
      pushExp(8'd20, 0, 0, 1, 0, 1);
      pushExp(8'd20, 0, 0, 0, 0, 2);
      checkOutput("single_tail", 10);

      // Triangle 10..20 step 5 dwell 2, then abort on a due step
      applyStimulus(2'b10, 8'd10, 8'd20, 8'd5, 16'd2);
      pushExp(8'd10, 1, 1, 0, 0, 1);
      checkOutput("tri_start", 1);
      bus.start_i = 1'b0;
      pushExp(8'd10, 0, 1, 0, 0, 1);
      pushExp(8'd15, 1, 1, 0, 0, 1); pushExp(8'd15, 0, 1, 0, 0, 1);
      pushExp(8'd20, 1, 1, 0, 0, 1); pushExp(8'd20, 0, 1, 0, 0, 1);
      pushExp(8'd15, 1, 1, 0, 0, 1); pushExp(8'd15, 0, 1, 0, 0, 1);
      pushExp(8'd10, 1, 1, 0, 0, 1); pushExp(8'd10, 0, 1, 0, 0, 1);
      pushExp(8'd15, 1, 1, 0, 0, 1); pushExp(8'd15, 0, 1, 0, 0, 1);
      pushExp(8'd20, 1, 1, 0, 0, 1); pushExp(8'd20, 0, 1, 0, 0, 1);
      checkOutput("tri_seq", 13);
      bus.abort_i = 1'b1;
      pushExp(8'd20, 0, 0, 0, 0, 1);
      checkOutput("tri_abort", 1);
      bus.abort_i = 1'b0;

      // Continuous ramp at the top of the range: reload every cycle, no wrap
      applyStimulus(2'b01, 8'd250, 8'd255, 8'd10, 16'd0);
      pushExp(8'd250, 1, 1, 0, 0, 1);
      checkOutput("cont_start", 1);
      bus.start_i = 1'b0;
      pushExp(8'd250, 1, 1, 0, 0, 4);
      checkOutput("cont_reload", 4);
      bus.abort_i = 1'b1;
      pushExp(8'd250, 0, 0, 0, 0, 1);
      checkOutput("cont_abort", 1);
      bus.abort_i = 1'b0;

      // Single mode with the same configuration, then reserved mode 11
      for (int m = 0; m < 2; m++) begin
         applyStimulus((m == 0) ? 2'b00 : 2'b11, 8'd250, 8'd255, 8'd10, 16'd0);
         pushExp(8'd250, 1, 1, 0, 0, 1);
         checkOutput("ovf_single_start", 1);
         bus.start_i = 1'b0;
         pushExp(8'd250, 0, 0, 1, 0, 1);
         pushExp(8'd250, 0, 0, 0, 0, 1);
         checkOutput("ovf_single_done", 2);
      end

      // Rejected starts: zero step, then start above stop
      applyStimulus(2'b00, 8'd10, 8'd20, 8'd0, 16'd4);
      pushExp(8'd250, 0, 0, 0, 1, 1);
      checkOutput("reject_step0", 1);
      bus.start_i = 1'b0;
      pushExp(8'd250, 0, 0, 0, 0, 1);
      checkOutput("reject_step0_after", 1);
      applyStimulus(2'b00, 8'd30, 8'd20, 8'd5, 16'd4);
      pushExp(8'd250, 0, 0, 0, 1, 1);
      checkOutput("reject_order", 1);
      bus.start_i = 1'b0;
      pushExp(8'd250, 0, 0, 0, 0, 1);
      checkOutput("reject_order_after", 1);

      // Degenerate start == stop in single mode
      applyStimulus(2'b00, 8'd40, 8'd40, 8'd5, 16'd3);
      pushExp(8'd40, 1, 1, 0, 0, 1);
      checkOutput("degen_start", 1);
      bus.start_i = 1'b0;
      pushExp(8'd40, 0, 1, 0, 0, 2);
      pushExp(8'd40, 0, 0, 1, 0, 1);
      pushExp(8'd40, 0, 0, 0, 0, 1);
      checkOutput("degen_tail", 4);

      // Abort during the second dwell of the single-up case
      applyStimulus(2'b00, 8'd10, 8'd20, 8'd5, 16'd4);
      pushExp(8'd10, 1, 1, 0, 0, 1);
      checkOutput("abort_start", 1);
      bus.start_i = 1'b0;
      pushExp(8'd10, 0, 1, 0, 0, 3);
      pushExp(8'd15, 1, 1, 0, 0, 1);
      pushExp(8'd15, 0, 1, 0, 0, 1);
      checkOutput("abort_run", 5);
      bus.abort_i = 1'b1;
      pushExp(8'd15, 0, 0, 0, 0, 1);
      checkOutput("abort_hit", 1);
      bus.abort_i = 1'b0;
      pushExp(8'd15, 0, 0, 0, 0, 2);
      checkOutput("abort_idle", 2);

      // Start together with abort in IDLE: start wins. Then reset mid-sweep.
      applyStimulus(2'b00, 8'd10, 8'd20, 8'd5, 16'd4);
      bus.abort_i = 1'b1;
      pushExp(8'd10, 1, 1, 0, 0, 1);
      checkOutput("start_vs_abort", 1);
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      pushExp(8'd10, 0, 1, 0, 0, 3);
      pushExp(8'd15, 1, 1, 0, 0, 1);
      checkOutput("restart_run", 4);
      rst_n = 1'b0;
      pushExp(8'd0, 0, 0, 0, 0, 1);
      checkOutput("mid_reset", 1);
      rst_n = 1'b1;
      pushExp(8'd0, 0, 0, 0, 0, 2);
      checkOutput("post_reset_idle", 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
